fdd_dma_controller: RTL and testbench

- Single-channel 8237-subset DMA controller (channel 2) plus page register, moving bytes between the floppy controller and system memory.
- Requests the bus from the CPU via hold_request/hold_acknowledge, then sequences address, strobes and terminal count for each byte.
- Sits beside the interrupt, timer and PPI blocks on the I/O bus. It is decoded by the existing DMA and DMA-page chip selects, and its memory cycles feed the RAM/VRAM/BIOS decode.

---
 rtl/fdd_dma_controller.sv | 206 ++++++++++++++++++++
 tb/tb_fdd_dma_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fdd_dma_controller.sv
// Single-channel 8237-subset DMA controller with page register for the floppy channel.
// One byte moves per bus grant: IDLE -> REQ -> S1 -> S2 (STROBE_CYCLES) -> S3 -> REL.
module fdd_dma_controller #(
    parameter int unsigned STROBE_CYCLES = 2,
    parameter logic [1:0]  DMA_CHANNEL   = 2'd2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dma_chip_select_n,
    input  logic        dma_page_chip_select_n,
    input  logic [3:0]  address,
    input  logic        io_read_n,
    input  logic        io_write_n,
    input  logic [7:0]  data_bus_in,
    output logic [7:0]  data_bus_out,
    input  logic        dma_req,
    output logic        dma_ack,
    output logic        dma_tc,
    input  logic [7:0]  fdd_readdata,
    output logic [7:0]  fdd_writedata,
    output logic        hold_request,
    input  logic        hold_acknowledge,
    output logic [19:0] mem_address,
    output logic        mem_read_n,
    output logic        mem_write_n,
    input  logic [7:0]  mem_data_in,
    output logic [7:0]  mem_data_out
);

    typedef enum logic [2:0] {IDLE, REQ, S1, S2, S3, REL} state_t;

    localparam int unsigned CW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

    state_t        state, state_next;
    logic [CW-1:0] strobe_cnt;
    logic          strobe_last;
    logic [15:0]   base_addr, cur_addr, base_count, cur_count;
    logic [3:0]    page;
    logic          mask, flip_flop, autoinit, decrement;
    logic [1:0]    xfer_type;
    logic          io_write_n_q, io_read_n_q;
    logic          write_pulse, read_pulse, dma_sel, page_sel;
    logic [19:0]   xfer_addr;
    logic [7:0]    fdd_wdata_q, rdata_q;
    logic          tc_now;

    assign dma_sel     = !dma_chip_select_n;
    assign page_sel    = !dma_page_chip_select_n;
    assign write_pulse = !io_write_n && io_write_n_q;
    assign read_pulse  = !io_read_n && io_read_n_q;
    assign strobe_last = (strobe_cnt == CW'(STROBE_CYCLES - 1));
    // Terminal count is judged on the pre-decrement count while in S3.
    assign tc_now      = (state == S3) && (cur_count == '0);

    assign mem_address   = xfer_addr;
    assign fdd_writedata = fdd_wdata_q;
    assign data_bus_out  = rdata_q;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (dma_req && !mask) state_next = REQ;
            REQ:     if (hold_acknowledge) state_next = S1;
            S1:      state_next = S2;
            S2:      if (strobe_last) state_next = S3;
            S3:      state_next = REL;
            REL:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        hold_request = 1'b0;
        dma_ack      = 1'b0;
        mem_read_n   = 1'b1;
        mem_write_n  = 1'b1;
        mem_data_out = '0;
        case (state)
            REQ: hold_request = 1'b1;
            S1, S3: begin
                hold_request = 1'b1;
                dma_ack      = 1'b1;
            end
            S2: begin
                hold_request = 1'b1;
                dma_ack      = 1'b1;
                if (xfer_type == 2'b01) begin
                    mem_write_n  = 1'b0;
                    mem_data_out = fdd_readdata;
                end else if (xfer_type == 2'b10) begin
                    mem_read_n = 1'b0;
                end
            end
            default: ;
        endcase
        dma_tc = tc_now;
    end

    always_ff @(posedge clock) begin
        if (reset || state != S2) strobe_cnt <= '0;
        else                      strobe_cnt <= strobe_cnt + 1'b1;
    end

    // Register writes come after the S3 update so a CPU write in the same cycle wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            base_addr    <= '0;
            cur_addr     <= '0;
            base_count   <= '0;
            cur_count    <= '0;
            page         <= '0;
            mask         <= 1'b1;
            flip_flop    <= 1'b0;
            autoinit     <= 1'b0;
            decrement    <= 1'b0;
            xfer_type    <= '0;
            io_write_n_q <= 1'b1;
            io_read_n_q  <= 1'b1;
            xfer_addr    <= '0;
            fdd_wdata_q  <= '0;
            rdata_q      <= '0;
        end else begin
            io_write_n_q <= io_write_n;
            io_read_n_q  <= io_read_n;

            if (state == REQ && hold_acknowledge) xfer_addr <= {page, cur_addr};
            if (state == S2 && strobe_last && xfer_type == 2'b10) fdd_wdata_q <= mem_data_in;

            if (state == S3) begin
                cur_addr  <= decrement ? cur_addr - 16'd1 : cur_addr + 16'd1;
                cur_count <= cur_count - 16'd1;
                if (tc_now) begin
                    if (autoinit) begin
                        cur_addr  <= base_addr;
                        cur_count <= base_count;
                    end else begin
                        mask <= 1'b1;
                    end
                end
            end

            if (write_pulse && dma_sel) begin
                case (address)
                    4'h4: begin
                        if (flip_flop) begin
                            base_addr[15:8] <= data_bus_in;
                            cur_addr[15:8]  <= data_bus_in;
                        end else begin
                            base_addr[7:0] <= data_bus_in;
                            cur_addr[7:0]  <= data_bus_in;
                        end
                        flip_flop <= !flip_flop;
                    end
                    4'h5: begin
                        if (flip_flop) begin
                            base_count[15:8] <= data_bus_in;
                            cur_count[15:8]  <= data_bus_in;
                        end else begin
                            base_count[7:0] <= data_bus_in;
                            cur_count[7:0]  <= data_bus_in;
                        end
                        flip_flop <= !flip_flop;
                    end
                    4'hA: if (data_bus_in[1:0] == DMA_CHANNEL) mask <= data_bus_in[2];
                    4'hB: begin
                        if (data_bus_in[1:0] == DMA_CHANNEL) begin
                            xfer_type <= data_bus_in[3:2];
                            autoinit  <= data_bus_in[4];
                            decrement <= data_bus_in[5];
                        end
                    end
                    4'hC: flip_flop <= 1'b0;
                    4'hD: begin
                        mask      <= 1'b1;
                        flip_flop <= 1'b0;
                    end
                    default: ;
                endcase
            end else if (write_pulse && page_sel && address == 4'h1) begin
                page <= data_bus_in[3:0];
            end

            if (read_pulse && dma_sel) begin
                case (address)
                    4'h4: begin
                        rdata_q   <= flip_flop ? cur_addr[15:8] : cur_addr[7:0];
                        flip_flop <= !flip_flop;
                    end
                    4'h5: begin
                        rdata_q   <= flip_flop ? cur_count[15:8] : cur_count[7:0];
                        flip_flop <= !flip_flop;
                    end
                    default: rdata_q <= '0;
                endcase
            end else if (read_pulse && page_sel) begin
                rdata_q <= (address == 4'h1) ? {4'b0000, page} : '0;
            end
        end
    end

endmodule

// File: tb/tb_fdd_dma_controller.sv
// Directed bench for fdd_dma_controller: register access, write/read/autoinit transfers,
// bus-grant stall and mid-transfer reset.
module tb_fdd_dma_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        dma_chip_select_n = 1'b1;
    logic        dma_page_chip_select_n = 1'b1;
    logic [3:0]  address = '0;
    logic        io_read_n = 1'b1;
    logic        io_write_n = 1'b1;
    logic [7:0]  data_bus_in = '0;
    logic [7:0]  data_bus_out;
    logic        dma_req = 1'b0;
    logic        dma_ack;
    logic        dma_tc;
    logic [7:0]  fdd_readdata = '0;
    logic [7:0]  fdd_writedata;
    logic        hold_request;
    logic        hold_acknowledge = 1'b1;
    logic [19:0] mem_address;
    logic        mem_read_n;
    logic        mem_write_n;
    logic [7:0]  mem_data_in = '0;
    logic [7:0]  mem_data_out;

    int checks = 0;
    int failures = 0;

    fdd_dma_controller #(.STROBE_CYCLES(2), .DMA_CHANNEL(2'd2)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .dma_chip_select_n      (dma_chip_select_n),
        .dma_page_chip_select_n (dma_page_chip_select_n),
        .address                (address),
        .io_read_n              (io_read_n),
        .io_write_n             (io_write_n),
        .data_bus_in            (data_bus_in),
        .data_bus_out           (data_bus_out),
        .dma_req                (dma_req),
        .dma_ack                (dma_ack),
        .dma_tc                 (dma_tc),
        .fdd_readdata           (fdd_readdata),
        .fdd_writedata          (fdd_writedata),
        .hold_request           (hold_request),
        .hold_acknowledge       (hold_acknowledge),
        .mem_address            (mem_address),
        .mem_read_n             (mem_read_n),
        .mem_write_n            (mem_write_n),
        .mem_data_in            (mem_data_in),
        .mem_data_out           (mem_data_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic io_wr(input logic to_page, input logic [3:0] a, input logic [7:0] d);
        address     = a;
        data_bus_in = d;
        if (to_page) dma_page_chip_select_n = 1'b0;
        else         dma_chip_select_n      = 1'b0;
        io_write_n = 1'b0;
        @(negedge clock);
        io_write_n             = 1'b1;
        dma_chip_select_n      = 1'b1;
        dma_page_chip_select_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic io_rd(input logic from_page, input logic [3:0] a, input logic [7:0] exp,
                         input string tag);
        address = a;
        if (from_page) dma_page_chip_select_n = 1'b0;
        else           dma_chip_select_n      = 1'b0;
        io_read_n = 1'b0;
        @(negedge clock);
        check(tag, data_bus_out, exp);
        io_read_n              = 1'b1;
        dma_chip_select_n      = 1'b1;
        dma_page_chip_select_n = 1'b1;
        @(negedge clock);
    endtask

    // One single-byte transfer with hold_acknowledge already high.
    task automatic xfer(input logic [19:0] exp_addr, input logic is_wr, input logic is_rd,
                        input logic exp_tc, input logic [7:0] d, input string tag);
        int unsigned n;
        dma_req      = 1'b1;
        fdd_readdata = d;
        mem_data_in  = d;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!hold_request && n < 20);
        check({tag, "_hreq"}, hold_request, 1'b1);
        dma_req = 1'b0;
        n = 0;
        while (!dma_ack && n < 20) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_ack"}, dma_ack, 1'b1);
        check({tag, "_addr"}, mem_address, exp_addr);
        check({tag, "_s1_wr_n"}, mem_write_n, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check({tag, "_s2_wr_n"}, mem_write_n, !is_wr);
            check({tag, "_s2_rd_n"}, mem_read_n, !is_rd);
            if (is_wr) check({tag, "_s2_wdata"}, mem_data_out, d);
            check({tag, "_s2_tc"}, dma_tc, 1'b0);
        end
        @(negedge clock);
        check({tag, "_s3_wr_n"}, mem_write_n, 1'b1);
        check({tag, "_s3_rd_n"}, mem_read_n, 1'b1);
        check({tag, "_s3_tc"}, dma_tc, exp_tc);
        check({tag, "_s3_hreq"}, hold_request, 1'b1);
        @(negedge clock);
        check({tag, "_rel_hreq"}, hold_request, 1'b0);
        check({tag, "_rel_ack"}, dma_ack, 1'b0);
        check({tag, "_rel_tc"}, dma_tc, 1'b0);
        if (is_rd) check({tag, "_fdd_wdata"}, fdd_writedata, d);
        @(negedge clock);
    endtask

    task automatic expect_no_hold(input int unsigned cycles, input string tag);
        dma_req = 1'b1;
        for (int unsigned i = 0; i < cycles; i++) begin
            @(negedge clock);
            check(tag, hold_request, 1'b0);
        end
        dma_req = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("rst_hreq", hold_request, 1'b0);
        check("rst_ack", dma_ack, 1'b0);
        check("rst_tc", dma_tc, 1'b0);
        check("rst_rd_n", mem_read_n, 1'b1);
        check("rst_wr_n", mem_write_n, 1'b1);
        check("rst_maddr", mem_address, 20'h0);
        check("rst_dbus", data_bus_out, 8'h00);
        reset = 1'b0;
        @(negedge clock);

        io_rd(1'b0, 4'h4, 8'h00, "rst_addr_lo");
        io_rd(1'b0, 4'h4, 8'h00, "rst_addr_hi");
        expect_no_hold(5, "rst_masked");

        // Write-to-memory, three bytes, incrementing.
        io_wr(1'b1, 4'h1, 8'h02);
        io_rd(1'b1, 4'h1, 8'h02, "page_rd");
        io_wr(1'b0, 4'hC, 8'h00);
        io_wr(1'b0, 4'h4, 8'h00);
        io_wr(1'b0, 4'h4, 8'h10);
        io_wr(1'b0, 4'h5, 8'h02);
        io_wr(1'b0, 4'h5, 8'h00);
        io_wr(1'b0, 4'hB, 8'h46);
        io_wr(1'b0, 4'hA, 8'h02);
        xfer(20'h21000, 1'b1, 1'b0, 1'b0, 8'hA5, "w0");
        xfer(20'h21001, 1'b1, 1'b0, 1'b0, 8'h5A, "w1");
        xfer(20'h21002, 1'b1, 1'b0, 1'b1, 8'h3C, "w2");
        expect_no_hold(5, "w_tc_masked");
        io_rd(1'b0, 4'h4, 8'h03, "w_cur_addr_lo");
        io_rd(1'b0, 4'h4, 8'h10, "w_cur_addr_hi");
        io_rd(1'b0, 4'h5, 8'hFF, "w_cur_cnt_lo");
        io_rd(1'b0, 4'h5, 8'hFF, "w_cur_cnt_hi");

        // Read-from-memory across the 16-bit address wrap; page stays put.
        io_wr(1'b0, 4'hC, 8'h00);
        io_wr(1'b0, 4'h4, 8'hFF);
        io_wr(1'b0, 4'h4, 8'hFF);
        io_wr(1'b0, 4'h5, 8'h01);
        io_wr(1'b0, 4'h5, 8'h00);
        io_wr(1'b0, 4'hB, 8'h4A);
        io_wr(1'b0, 4'hA, 8'h02);
        xfer(20'h2FFFF, 1'b0, 1'b1, 1'b0, 8'h77, "r0");
        xfer(20'h20000, 1'b0, 1'b1, 1'b1, 8'h88, "r1");
        expect_no_hold(3, "r_tc_masked");

        // Autoinit: TC on the first byte, reload, channel stays unmasked.
        io_wr(1'b0, 4'hC, 8'h00);
        io_wr(1'b0, 4'h4, 8'h34);
        io_wr(1'b0, 4'h4, 8'h12);
        io_wr(1'b0, 4'h5, 8'h00);
        io_wr(1'b0, 4'h5, 8'h00);
        io_wr(1'b0, 4'hB, 8'h56);
        io_wr(1'b0, 4'hA, 8'h02);
        xfer(20'h21234, 1'b1, 1'b0, 1'b1, 8'hC3, "ai");
        io_rd(1'b0, 4'h4, 8'h34, "ai_addr_lo");
        io_rd(1'b0, 4'h4, 8'h12, "ai_addr_hi");
        io_rd(1'b0, 4'h5, 8'h00, "ai_cnt_lo");
        io_rd(1'b0, 4'h5, 8'h00, "ai_cnt_hi");

        // Grant withheld for 10 cycles, then granted; reset lands in S2.
        hold_acknowledge = 1'b0;
        fdd_readdata     = 8'h11;
        dma_req          = 1'b1;
        @(negedge clock);
        check("stall_enter_req", hold_request, 1'b1);
        dma_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("stall_hreq", hold_request, 1'b1);
            check("stall_ack", dma_ack, 1'b0);
            check("stall_wr_n", mem_write_n, 1'b1);
        end
        hold_acknowledge = 1'b1;
        @(negedge clock);
        check("grant_ack", dma_ack, 1'b1);
        check("grant_addr", mem_address, 20'h21234);
        @(negedge clock);
        check("pre_rst_wr_n", mem_write_n, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_wr_n", mem_write_n, 1'b1);
        check("mid_rst_hreq", hold_request, 1'b0);
        check("mid_rst_ack", dma_ack, 1'b0);
        check("mid_rst_maddr", mem_address, 20'h0);
        reset = 1'b0;
        @(negedge clock);
        expect_no_hold(4, "mid_rst_masked");
        io_rd(1'b0, 4'h4, 8'h00, "mid_rst_addr_lo");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
